// File: rtl/spi_tx_buf_mc_if.sv
// spi_tx_buf_mc_if: push/pop handshake and per-channel status bundle for spi_tx_buf_mc.
interface spi_tx_buf_mc_if #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 11,
  parameter int NCH = 2,
  parameter int CHW = 1
);
  logic wen;
  logic [CHW-1:0] wch;
  logic [DATAWIDTH-1:0] wdata;
  logic ren;
  logic [CHW-1:0] rch;
  logic [DATAWIDTH-1:0] rdata;
  logic rvalid;
  logic [NCH-1:0] flush;
  logic err_clr;
  logic [NCH-1:0] full;
  logic [NCH-1:0] empty;
  logic [NCH*(ADDRWIDTH+1)-1:0] level;
  logic [NCH-1:0] ovf;
  logic [NCH-1:0] udf;
  modport master (
    output wen, wch, wdata, ren, rch, flush, err_clr,
    input rdata, rvalid, full, empty, level, ovf, udf
  );
  modport slave (
    input wen, wch, wdata, ren, rch, flush, err_clr,
    output rdata, rvalid, full, empty, level, ovf, udf
  );
endinterface

// File: rtl/spi_tx_buf_mc.sv
// spi_tx_buf_mc: per-channel circular TX FIFOs sharing one RAM, with registered flags, sticky errors and flush.
// Define SPI_TXBUF_EDGE_REN_EN to pop on the rising edge of ren instead of every cycle ren is high.
module spi_tx_buf_mc #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 11,
  parameter int NCH = 2,
  parameter int CHW = 1
) (
  input logic clk0,
  input logic rstn,
  spi_tx_buf_mc_if.slave bus
);
  localparam int PW = ADDRWIDTH + 1;
  logic [PW-1:0] wptr_q [NCH];
  logic [PW-1:0] wptr_d [NCH];
  logic [PW-1:0] rptr_q [NCH];
  logic [PW-1:0] rptr_d [NCH];
  logic [PW-1:0] level_q [NCH];
  logic [PW-1:0] level_d [NCH];
  logic [NCH-1:0] full_q, full_d, empty_q, empty_d, ovf_q, ovf_d, udf_q, udf_d;
  logic [DATAWIDTH-1:0] mem_q [NCH*(2**ADDRWIDTH)];
  logic [DATAWIDTH-1:0] rdata_q;
  logic rvalid_q;
  logic pop_ev, pop_ok, push_ok;
`ifdef SPI_TXBUF_EDGE_REN_EN
  logic ren_q;
  always_ff @(posedge clk0) ren_q <= rstn ? bus.ren : 1'b0;
  assign pop_ev = bus.ren && !ren_q;
`else
  assign pop_ev = bus.ren;
`endif
  always_comb begin
    pop_ok = pop_ev && !empty_q[bus.rch] && !bus.flush[bus.rch];
    // a full channel can still take a push when the same cycle frees a slot on it
    push_ok = bus.wen && !bus.flush[bus.wch] && (!full_q[bus.wch] || (pop_ok && bus.rch == bus.wch));
    for (int c = 0; c < NCH; c++) begin
      wptr_d[c] = bus.flush[c] ? '0 : wptr_q[c] + PW'(push_ok && bus.wch == CHW'(c));
      rptr_d[c] = bus.flush[c] ? '0 : rptr_q[c] + PW'(pop_ok && bus.rch == CHW'(c));
      level_d[c] = wptr_d[c] - rptr_d[c];
      empty_d[c] = wptr_d[c] == rptr_d[c];
      full_d[c] = level_d[c][ADDRWIDTH];
      ovf_d[c] = (ovf_q[c] && !bus.err_clr) || (bus.wen && bus.wch == CHW'(c) && !bus.flush[c] && !push_ok);
      udf_d[c] = (udf_q[c] && !bus.err_clr) || (pop_ev && bus.rch == CHW'(c) && !bus.flush[c] && empty_q[c]);
    end
  end
  always_ff @(posedge clk0) begin
    if (!rstn) begin
      wptr_q <= '{default: '0};
      rptr_q <= '{default: '0};
      level_q <= '{default: '0};
      full_q <= '0;
      empty_q <= '1;
      ovf_q <= '0;
      udf_q <= '0;
      rdata_q <= '0;
      rvalid_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      level_q <= level_d;
      full_q <= full_d;
      empty_q <= empty_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
      rvalid_q <= pop_ok;
      if (pop_ok) rdata_q <= mem_q[{bus.rch, rptr_q[bus.rch][ADDRWIDTH-1:0]}];
    end
  end
  always_ff @(posedge clk0)
    if (rstn && push_ok) mem_q[{bus.wch, wptr_q[bus.wch][ADDRWIDTH-1:0]}] <= bus.wdata;
  assign bus.rdata = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign bus.full = full_q;
  assign bus.empty = empty_q;
  assign bus.ovf = ovf_q;
  assign bus.udf = udf_q;
  for (genvar i = 0; i < NCH; i++) begin : g_lvl
    assign bus.level[i*PW +: PW] = level_q[i];
  end
endmodule
